// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between instruction fetch and
//               load/store. Optional macro MEM_ARB_RR_EN selects round-robin
//               tie-breaking instead of fixed data-over-fetch priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int MASK_W    = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_imem_req,
    input  logic [ADDR_WIDTH-1:0] i_imem_addr,
    output logic [DATA_WIDTH-1:0] o_imem_rdata,
    output logic                  o_imem_valid,
    input  logic                  i_dmem_req,
    input  logic                  i_dmem_we,
    input  logic [ADDR_WIDTH-1:0] i_dmem_addr,
    input  logic [DATA_WIDTH-1:0] i_dmem_wdata,
    input  logic [MASK_W-1:0]     i_dmem_mask,
    output logic [DATA_WIDTH-1:0] o_dmem_rdata,
    output logic                  o_dmem_valid,
    input  logic                  i_halt,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [MASK_W-1:0]     o_mem_mask,
    input  logic                  i_mem_ready,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                  w_i_elig;
    logic                  w_d_elig;
    logic                  w_grant_i;
    logic                  w_grant_d;
    logic                  w_load;
    logic                  w_done;

    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [MASK_W-1:0]     r_mem_mask;
    logic [DATA_WIDTH-1:0] r_imem_rdata;
    logic [DATA_WIDTH-1:0] r_dmem_rdata;
    logic                  r_imem_valid;
    logic                  r_dmem_valid;

    assign w_i_elig = i_imem_req & ~i_halt;
    assign w_d_elig = i_dmem_req;

`ifdef MEM_ARB_RR_EN
    // 1 = data side won most recently; reset favours data on the first tie
    logic r_last_grant;

    assign w_grant_d = w_d_elig & (~w_i_elig | ~r_last_grant);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= 1'b0;
        end else if (w_load) begin
            r_last_grant <= w_grant_d;
        end
    end
`else
    assign w_grant_d = w_d_elig;
`endif

    assign w_grant_i = w_i_elig & ~w_grant_d;
    assign w_load    = (r_state == IDLE) & (w_grant_i | w_grant_d);
    assign w_done    = ((r_state == BUSY_I) | (r_state == BUSY_D)) & i_mem_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_next = BUSY_D;
                end else if (w_grant_i) begin
                    w_state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (i_mem_ready) begin
                    w_state_next = RESP;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_mask   <= '0;
            r_imem_rdata <= '0;
            r_dmem_rdata <= '0;
            r_imem_valid <= 1'b0;
            r_dmem_valid <= 1'b0;
        end else begin
            r_imem_valid <= 1'b0;
            r_dmem_valid <= 1'b0;
            if (w_load) begin
                r_mem_req <= 1'b1;
                if (w_grant_d) begin
                    r_mem_we    <= i_dmem_we;
                    r_mem_addr  <= i_dmem_addr;
                    r_mem_wdata <= i_dmem_wdata;
                    r_mem_mask  <= i_dmem_mask;
                end else begin
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= i_imem_addr;
                    r_mem_wdata <= '0;
                    r_mem_mask  <= '1;
                end
            end
            if (w_done) begin
                r_mem_req <= 1'b0;
                if (r_state == BUSY_I) begin
                    r_imem_rdata <= i_mem_rdata;
                    r_imem_valid <= 1'b1;
                end else begin
                    // a store keeps the previous load data visible
                    if (!r_mem_we) begin
                        r_dmem_rdata <= i_mem_rdata;
                    end
                    r_dmem_valid <= 1'b1;
                end
            end
        end
    end

    assign o_mem_req    = r_mem_req;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_mem_mask   = r_mem_mask;
    assign o_imem_rdata = r_imem_rdata;
    assign o_imem_valid = r_imem_valid;
    assign o_dmem_rdata = r_dmem_rdata;
    assign o_dmem_valid = r_dmem_valid;
    assign o_busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter with requester and
//               memory models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_imem_req;
    logic [31:0] i_imem_addr;
    logic [31:0] o_imem_rdata;
    logic        o_imem_valid;
    logic        i_dmem_req;
    logic        i_dmem_we;
    logic [31:0] i_dmem_addr;
    logic [31:0] i_dmem_wdata;
    logic [3:0]  i_dmem_mask;
    logic [31:0] o_dmem_rdata;
    logic        o_dmem_valid;
    logic        i_halt;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_ready;
    logic [31:0] i_mem_rdata;
    logic        o_busy;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_imem_req(i_imem_req), .i_imem_addr(i_imem_addr),
        .o_imem_rdata(o_imem_rdata), .o_imem_valid(o_imem_valid),
        .i_dmem_req(i_dmem_req), .i_dmem_we(i_dmem_we), .i_dmem_addr(i_dmem_addr),
        .i_dmem_wdata(i_dmem_wdata), .i_dmem_mask(i_dmem_mask),
        .o_dmem_rdata(o_dmem_rdata), .o_dmem_valid(o_dmem_valid),
        .i_halt(i_halt),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
        .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_i[$];
    exp_t        exp_d[$];
    exp_t        d_jobs[$];
    logic [31:0] f_jobs[$];
    int          grant_log[$];
    int          i_valid_cyc[$];

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int mem_lat = 0;
    logic mem_hold = 1'b0;
    int f_req_cyc = 0, d_req_cyc = 0, i_lat = 0, d_lat = 0;
    int n_iv = 0, n_dv = 0, tot_i = 0, tot_d = 0;
    int overlap_cnt = 0, dup_cnt = 0;
    logic [31:0] last_d = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic push_fetch(input logic [31:0] a);
        exp_t e;
        e.addr = a; e.we = 1'b0; e.wdata = '0; e.mask = 4'hF; e.rdata = mem_word(a);
        f_jobs.push_back(a);
        exp_i.push_back(e);
        tot_i++;
    endtask

    task automatic push_data(input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] m);
        exp_t e;
        if (!we) last_d = mem_word(a);
        e.addr = a; e.we = we; e.wdata = wd; e.mask = m; e.rdata = last_d;
        d_jobs.push_back(e);
        exp_d.push_back(e);
        tot_d++;
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    // fetch requester: level-held, next operands applied the cycle after valid
    initial begin : fetch_driver
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(posedge i_clk); #1;
            if (prev_v) begin
                if (f_jobs.size() > 0) begin
                    i_imem_addr = f_jobs.pop_front();
                    f_req_cyc   = cyc;
                end else begin
                    i_imem_req = 1'b0;
                end
            end else if (!i_imem_req && f_jobs.size() > 0) begin
                i_imem_addr = f_jobs.pop_front();
                i_imem_req  = 1'b1;
                f_req_cyc   = cyc;
            end
            prev_v = o_imem_valid;
        end
    end

    initial begin : data_driver
        logic prev_v;
        exp_t j;
        prev_v = 1'b0;
        forever begin
            @(posedge i_clk); #1;
            if ((prev_v || !i_dmem_req) && d_jobs.size() > 0) begin
                j = d_jobs.pop_front();
                i_dmem_we = j.we; i_dmem_addr = j.addr;
                i_dmem_wdata = j.wdata; i_dmem_mask = j.mask;
                i_dmem_req = 1'b1;
                d_req_cyc  = cyc;
            end else if (prev_v) begin
                i_dmem_req = 1'b0;
            end
            prev_v = o_dmem_valid;
        end
    end

    initial begin : memory_model
        int wait_cnt;
        wait_cnt = 0;
        i_mem_ready = 1'b0;
        i_mem_rdata = '0;
        forever begin
            @(posedge i_clk); #1;
            i_mem_ready = 1'b0;
            i_mem_rdata = 32'hBAD0_0000 | cyc;
            if (o_mem_req && !mem_hold) begin
                if (wait_cnt >= mem_lat) begin
                    i_mem_ready = 1'b1;
                    i_mem_rdata = mem_word(o_mem_addr);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else if (!o_mem_req) begin
                wait_cnt = 0;
            end
        end
    end

    initial begin : monitor
        logic prev_req, prev_iv, prev_dv, unstable;
        logic [31:0] c_addr, c_wdata;
        logic c_we;
        logic [3:0] c_mask;
        exp_t e;
        prev_req = 0; prev_iv = 0; prev_dv = 0; unstable = 0;
        c_addr = '0; c_wdata = '0; c_we = 0; c_mask = '0;
        forever begin
            @(posedge i_clk); #1;
            if (o_mem_req && !prev_req) begin
                c_addr = o_mem_addr; c_we = o_mem_we; c_wdata = o_mem_wdata; c_mask = o_mem_mask;
                unstable = 1'b0;
            end else if (o_mem_req && ({o_mem_addr, o_mem_we, o_mem_wdata, o_mem_mask} !==
                                        {c_addr, c_we, c_wdata, c_mask})) begin
                unstable = 1'b1;
            end
            prev_req = o_mem_req;
            if (o_imem_valid && o_dmem_valid) overlap_cnt++;
            if ((o_imem_valid && prev_iv) || (o_dmem_valid && prev_dv)) dup_cnt++;
            prev_iv = o_imem_valid;
            prev_dv = o_dmem_valid;
            if (o_imem_valid) begin
                n_iv++;
                grant_log.push_back(0);
                i_valid_cyc.push_back(cyc);
                i_lat = cyc - f_req_cyc;
                if (exp_i.size() == 0) check("imem_unexpected_valid", 1, 0);
                else begin
                    e = exp_i.pop_front();
                    check("imem_mem_addr", c_addr, e.addr);
                    check("imem_mem_we", c_we, 1'b0);
                    check("imem_mem_mask", c_mask, 4'hF);
                    check("imem_rdata", o_imem_rdata, e.rdata);
                    check("imem_stable", unstable, 1'b0);
                end
            end
            if (o_dmem_valid) begin
                n_dv++;
                grant_log.push_back(1);
                d_lat = cyc - d_req_cyc;
                if (exp_d.size() == 0) check("dmem_unexpected_valid", 1, 0);
                else begin
                    e = exp_d.pop_front();
                    check("dmem_mem_addr", c_addr, e.addr);
                    check("dmem_mem_we", c_we, e.we);
                    check("dmem_mem_mask", c_mask, e.mask);
                    if (e.we) check("dmem_mem_wdata", c_wdata, e.wdata);
                    check("dmem_rdata", o_dmem_rdata, e.rdata);
                    check("dmem_stable", unstable, 1'b0);
                end
            end
        end
    end

    task automatic wait_drain();
        int t;
        t = 0;
        while ((f_jobs.size() > 0 || d_jobs.size() > 0 || exp_i.size() > 0 || exp_d.size() > 0 ||
                i_imem_req || i_dmem_req || o_busy) && t < 3000) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 3000) check("drain_timeout", 1, 0);
        repeat (2) @(negedge i_clk);
    endtask

    initial begin : main
        int t, n_before, halt_cyc, exp_side;
        i_rst = 1'b1; i_halt = 1'b0;
        i_imem_req = 1'b0; i_imem_addr = '0;
        i_dmem_req = 1'b0; i_dmem_we = 1'b0; i_dmem_addr = '0; i_dmem_wdata = '0; i_dmem_mask = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_mem_req", o_mem_req, 0);
        check("rst_busy", o_busy, 0);
        check("rst_valids", {o_imem_valid, o_dmem_valid}, 0);
        check("rst_rdata", {o_imem_rdata, o_dmem_rdata}, 0);
        check("rst_mem_bus", {o_mem_we, o_mem_addr, o_mem_mask}, 0);
        check("rst_mem_wdata", o_mem_wdata, 0);
        i_rst = 1'b0;

        // fetch with two wait states
        mem_lat = 2;
        grant_log.delete();
        @(negedge i_clk);
        push_fetch(32'h100);
        wait_drain();
        check("fetch_latency", i_lat, 4);
        check("fetch_no_dvalid", n_dv, 0);
        check("fetch_grants", grant_log.size(), 1);

        // zero-wait store keeps load data at reset value
        mem_lat = 0;
        @(negedge i_clk);
        push_data(1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011);
        wait_drain();
        check("store_latency", d_lat, 2);
        check("store_rdata_kept", o_dmem_rdata, 0);

        // back-to-back fetches with req held
        i_valid_cyc.delete();
        @(negedge i_clk);
        push_fetch(32'h0);
        push_fetch(32'h4);
        wait_drain();
        check("b2b_count", i_valid_cyc.size(), 2);
        if (i_valid_cyc.size() >= 2) check("b2b_gap", i_valid_cyc[1] - i_valid_cyc[0], 3);

        // halt blocks fetch grants only
        grant_log.delete();
        i_valid_cyc.delete();
        @(negedge i_clk);
        i_halt = 1'b1;
        push_fetch(32'h40);
        push_data(1'b0, 32'h300, 32'h0, 4'hF);
        push_data(1'b1, 32'h304, 32'h0BAD_F00D, 4'b1100);
        t = 0;
        while (exp_d.size() > 0 && t < 1000) begin @(negedge i_clk); t++; end
        if (t >= 1000) check("halt_timeout", 1, 0);
        repeat (4) @(negedge i_clk);
        check("halt_fetch_pending", exp_i.size(), 1);
        check("halt_data_grants", grant_log.size(), 2);
        @(negedge i_clk);
        halt_cyc = cyc;
        i_halt = 1'b0;
        wait_drain();
        check("halt_release_grant", (grant_log.size() == 3) ? grant_log[2] : -1, 0);
        check("halt_release_latency", (i_valid_cyc.size() == 1) ? i_valid_cyc[0] - halt_cyc : -1, 2);

        // reset while a fetch waits on memory
        mem_hold = 1'b1;
        @(negedge i_clk);
        push_fetch(32'h80);
        t = 0;
        while (!o_mem_req && t < 100) begin @(negedge i_clk); t++; end
        if (t >= 100) check("rst_grant_timeout", 1, 0);
        repeat (2) @(posedge i_clk);
        #1;
        n_before = n_iv;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        check("midrst_mem_req", o_mem_req, 0);
        check("midrst_busy", o_busy, 0);
        check("midrst_imem_rdata", o_imem_rdata, 0);
        check("midrst_dmem_rdata", o_dmem_rdata, 0);
        check("midrst_no_valid", o_imem_valid, 0);
        last_d = '0;
        i_rst = 1'b0;
        mem_hold = 1'b0;
        wait_drain();
        check("midrst_one_completion", n_iv, n_before + 1);

        // continuous contention from both sides, fresh arbitration state
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        last_d = '0;
        grant_log.delete();
        @(negedge i_clk);
        for (int k = 0; k < 6; k++) begin
            push_fetch(32'h1000 + 4 * k);
            push_data(k[0], 32'h2000 + 4 * k, 32'h1111_1111 * k + 1, 4'((k % 15) + 1));
        end
        wait_drain();
        check("contend_grants", grant_log.size(), 12);
        for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_side = (k % 2 == 0) ? 1 : 0;
`else
            exp_side = 1;
`endif
            check($sformatf("contend_grant_%0d", k), (grant_log.size() > k) ? grant_log[k] : -1, exp_side);
        end

        check("valid_overlap", overlap_cnt, 0);
        check("valid_width", dup_cnt, 0);
        check("total_imem_valid", n_iv, tot_i);
        check("total_dmem_valid", n_dv, tot_d);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
